// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, ALU operations,
// store widths, FSM states and the select/cause codes driven onto the datapath.
package mc_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_SLL  = 5'd2,
    ALU_SLT  = 5'd3,
    ALU_SLTU = 5'd4,
    ALU_XOR  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_OR   = 5'd8,
    ALU_AND  = 5'd9,
    ALU_EQ   = 5'd10,
    ALU_NE   = 5'd11,
    ALU_LT   = 5'd12,
    ALU_GE   = 5'd13,
    ALU_LTU  = 5'd14,
    ALU_GEU  = 5'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    WRITE_IDLE = 2'b00,
    WRITE_BYTE = 2'b01,
    WRITE_HALF = 2'b10,
    WRITE_WORD = 2'b11
  } mem_write_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10
  } pc_src_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_MDU = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    SRC_A_RS1  = 2'b00,
    SRC_A_PC   = 2'b01,
    SRC_A_ZERO = 2'b10
  } src_a_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_BUS     = 2'b10
  } fault_cause_e;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_MDU_WAIT, S_FAULT
  } state_e;

  typedef enum logic [3:0] {
    CLS_ALU_REG, CLS_ALU_IMM, CLS_LOAD, CLS_STORE, CLS_BRANCH,
    CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_MDU
  } instr_class_e;

  function automatic mem_write_e store_width(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return WRITE_BYTE;
      2'd1:    return WRITE_HALF;
      default: return WRITE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct3/funct7 to ALU operation,
// instruction class and an illegal-instruction flag.
module mc_decode import mc_pkg::*; #(
  parameter int ENABLE_M = 0
) (
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic [6:0]   funct7,
  output alu_op_e      alu_op,
  output instr_class_e cls,
  output logic         illegal
);

  function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic alu_op_e branch_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_EQ;
      3'b001:  return ALU_NE;
      3'b100:  return ALU_LT;
      3'b101:  return ALU_GE;
      3'b110:  return ALU_LTU;
      default: return ALU_GEU;
    endcase
  endfunction

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    alu_op  = ALU_ADD;
    cls     = CLS_ALU_REG;
    illegal = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        cls     = CLS_LOAD;
        illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      OPC_STORE: begin
        cls     = CLS_STORE;
        illegal = (funct3 > 3'd2);
      end
      OPC_BRANCH: begin
        cls     = CLS_BRANCH;
        alu_op  = branch_op(funct3);
        illegal = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      OPC_JAL:   cls = CLS_JAL;
      OPC_JALR:  cls = CLS_JALR;
      OPC_LUI:   cls = CLS_LUI;
      OPC_AUIPC: cls = CLS_AUIPC;
      OPC_OP_IMM: begin
        cls    = CLS_ALU_IMM;
        // Only the shift-right immediate borrows funct7 as an opcode extension (SRAI).
        alu_op = arith_op(funct3, (funct3 == 3'b101) && (funct7 == F7_ALT));
        if (funct3 == 3'b001)
          illegal = (funct7 != F7_BASE);
        else if (funct3 == 3'b101)
          illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
      end
      OPC_OP: begin
        if ((funct7 == F7_MULDIV) && (ENABLE_M != 0)) begin
          cls = CLS_MDU;
        end else if (funct7 == F7_BASE) begin
          alu_op = arith_op(funct3, 1'b0);
        end else if (funct7 == F7_ALT) begin
          alu_op  = arith_op(funct3, 1'b1);
          illegal = (funct3 != 3'b000) && (funct3 != 3'b101);
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// handles memory wait timeouts, MDU handshakes, illegal-instruction traps and instret.
module mc_controller import mc_pkg::*; #(
  parameter int ENABLE_M    = 0,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             branch_taken,
  input  logic             mem_ready,
  input  logic             mdu_done,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             mem_req,
  output logic             mem_read,
  output logic [1:0]       mem_write,
  output logic [1:0]       alu_src_a,
  output logic             alu_src_b,
  output logic [4:0]       alu_op,
  output logic             mdu_start,
  output logic [2:0]       mdu_op,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             fault,
  output logic [1:0]       fault_cause
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e       state, state_next;
  fault_cause_e cause_q, cause_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic         timeout;

  alu_op_e      dec_alu_op;
  instr_class_e dec_cls;
  logic         dec_illegal;

  mc_decode #(.ENABLE_M(ENABLE_M)) u_decode (
    .opcode  (opcode),
    .funct3  (funct3),
    .funct7  (funct7),
    .alu_op  (dec_alu_op),
    .cls     (dec_cls),
    .illegal (dec_illegal)
  );

  // The last permitted wait cycle with no response trips the bus fault.
  assign timeout = TIMEOUT_EN && mem_req && !mem_ready && (wait_cnt == WAIT_LAST);

  assign fault       = (state == S_FAULT);
  assign fault_cause = cause_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      cause_q  <= CAUSE_NONE;
      wait_cnt <= '0;
      instret  <= '0;
    end else begin
      state   <= state_next;
      cause_q <= cause_next;
      if (state_next != state)
        wait_cnt <= '0;
      else if (mem_req && !mem_ready)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if (retire)
        instret <= instret + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    cause_next = cause_q;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_PLUS4;
    mem_req    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = WRITE_IDLE;
    alu_src_a  = SRC_A_RS1;
    alu_src_b  = 1'b0;
    alu_op     = ALU_ADD;
    mdu_start  = 1'b0;
    mdu_op     = 3'b000;
    reg_write  = 1'b0;
    wb_sel     = WB_ALU;
    retire     = 1'b0;

    // Reset forces every strobe low immediately, even though the state already reads FETCH.
    if (!rst) begin
      if ((state == S_EXEC) || (state == S_MEM) || (state == S_WB)) begin
        alu_op    = dec_alu_op;
        alu_src_b = !((dec_cls == CLS_ALU_REG) || (dec_cls == CLS_BRANCH) || (dec_cls == CLS_MDU));
        if ((dec_cls == CLS_AUIPC) || (dec_cls == CLS_JAL))
          alu_src_a = SRC_A_PC;
        else if (dec_cls == CLS_LUI)
          alu_src_a = SRC_A_ZERO;
      end

      case (state)
        S_FETCH: begin
          mem_req  = 1'b1;
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write   = 1'b1;
            state_next = S_DECODE;
          end else if (timeout) begin
            state_next = S_FAULT;
            cause_next = CAUSE_BUS;
          end
        end
        S_DECODE: begin
          if (dec_illegal) begin
            state_next = S_FAULT;
            cause_next = CAUSE_ILLEGAL;
          end else begin
            state_next = S_EXEC;
          end
        end
        S_EXEC: begin
          case (dec_cls)
            CLS_BRANCH: begin
              pc_write   = 1'b1;
              pc_src     = branch_taken ? PC_BRANCH : PC_PLUS4;
              retire     = 1'b1;
              state_next = S_FETCH;
            end
            CLS_JAL, CLS_JALR: begin
              pc_write   = 1'b1;
              pc_src     = (dec_cls == CLS_JAL) ? PC_BRANCH : PC_JALR;
              reg_write  = 1'b1;
              wb_sel     = WB_PC4;
              retire     = 1'b1;
              state_next = S_FETCH;
            end
            CLS_LOAD, CLS_STORE: state_next = S_MEM;
            CLS_MDU: begin
              mdu_start  = 1'b1;
              mdu_op     = funct3;
              state_next = S_MDU_WAIT;
            end
            default: state_next = S_WB;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          if (dec_cls == CLS_LOAD)
            mem_read = 1'b1;
          else
            mem_write = store_width(funct3);
          if (mem_ready) begin
            if (dec_cls == CLS_STORE) begin
              pc_write   = 1'b1;
              retire     = 1'b1;
              state_next = S_FETCH;
            end else begin
              state_next = S_WB;
            end
          end else if (timeout) begin
            state_next = S_FAULT;
            cause_next = CAUSE_BUS;
          end
        end
        S_MDU_WAIT: begin
          mdu_op = funct3;
          if (mdu_done)
            state_next = S_WB;
        end
        S_WB: begin
          reg_write  = 1'b1;
          pc_write   = 1'b1;
          retire     = 1'b1;
          state_next = S_FETCH;
          if (dec_cls == CLS_LOAD)
            wb_sel = WB_MEM;
          else if (dec_cls == CLS_MDU)
            wb_sel = WB_MDU;
        end
        S_FAULT: state_next = S_FAULT;
        default: state_next = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: one instance without the M extension and one with it,
// both with a 4-cycle memory timeout, driven by the same instruction stream.
module tb_mc_controller;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       branch_taken, mem_ready, mdu_done;

  logic        ir_write, pc_write, mem_req, mem_read, alu_src_b, mdu_start, reg_write, retire, fault;
  logic [1:0]  pc_src, mem_write, alu_src_a, wb_sel, fault_cause;
  logic [4:0]  alu_op;
  logic [2:0]  mdu_op;
  logic [31:0] instret;

  logic        m_ir_write, m_pc_write, m_mem_req, m_mem_read, m_alu_src_b, m_mdu_start, m_reg_write, m_retire, m_fault;
  logic [1:0]  m_pc_src, m_mem_write, m_alu_src_a, m_wb_sel, m_fault_cause;
  logic [4:0]  m_alu_op;
  logic [2:0]  m_mdu_op;
  logic [31:0] m_instret;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mc_controller #(.ENABLE_M(0), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .branch_taken(branch_taken), .mem_ready(mem_ready), .mdu_done(mdu_done),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .mem_req(mem_req),
    .mem_read(mem_read), .mem_write(mem_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .mdu_start(mdu_start), .mdu_op(mdu_op), .reg_write(reg_write),
    .wb_sel(wb_sel), .retire(retire), .instret(instret), .fault(fault), .fault_cause(fault_cause)
  );

  mc_controller #(.ENABLE_M(1), .MEM_TIMEOUT(4), .CNT_W(32)) dut_m (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .branch_taken(branch_taken), .mem_ready(mem_ready), .mdu_done(mdu_done),
    .ir_write(m_ir_write), .pc_write(m_pc_write), .pc_src(m_pc_src), .mem_req(m_mem_req),
    .mem_read(m_mem_read), .mem_write(m_mem_write), .alu_src_a(m_alu_src_a), .alu_src_b(m_alu_src_b),
    .alu_op(m_alu_op), .mdu_start(m_mdu_start), .mdu_op(m_mdu_op), .reg_write(m_reg_write),
    .wb_sel(m_wb_sel), .retire(m_retire), .instret(m_instret), .fault(m_fault), .fault_cause(m_fault_cause)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
    opcode = opc;
    funct3 = f3;
    funct7 = f7;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_instr(OPC_OP, 3'b000, F7_BASE);
    branch_taken = 1'b0;
    mem_ready    = 1'b1;
    mdu_done     = 1'b0;
    settle();
    check("rst_mem_req", mem_req, 0);
    check("rst_ir_write", ir_write, 0);
    check("rst_pc_write", pc_write, 0);
    check("rst_fault", fault, 0);
    check("rst_cause", fault_cause, CAUSE_NONE);
    check("rst_instret", instret, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ADD with an always-ready memory: FETCH, DECODE, EXEC, WB.
    settle();
    check("add_f_req", mem_req, 1);
    check("add_f_read", mem_read, 1);
    check("add_f_irw", ir_write, 1);
    cyc(); settle();
    check("add_d_req", mem_req, 0);
    check("add_d_irw", ir_write, 0);
    cyc(); settle();
    check("add_e_aluop", alu_op, ALU_ADD);
    check("add_e_srcb", alu_src_b, 0);
    check("add_e_regw", reg_write, 0);
    cyc(); settle();
    check("add_w_regw", reg_write, 1);
    check("add_w_retire", retire, 1);
    check("add_w_pcw", pc_write, 1);
    check("add_w_wbsel", wb_sel, WB_ALU);
    check("add_w_instret", instret, 0);

    // LW with three stalled cycles in both FETCH and MEM: 11 cycles total.
    cyc();
    set_instr(OPC_LOAD, 3'b010, F7_BASE);
    mem_ready = 1'b0;
    settle();
    check("add_instret", instret, 1);
    check("add_retire_off", retire, 0);
    check("lw_f1_req", mem_req, 1);
    check("lw_f1_irw", ir_write, 0);
    cyc(); settle();
    check("lw_f2_req", mem_req, 1);
    cyc(); settle();
    check("lw_f3_req", mem_req, 1);
    cyc(); mem_ready = 1'b1; settle();
    check("lw_f4_irw", ir_write, 1);
    cyc(); settle();
    check("lw_d_req", mem_req, 0);
    cyc(); mem_ready = 1'b0; settle();
    check("lw_e_aluop", alu_op, ALU_ADD);
    check("lw_e_srcb", alu_src_b, 1);
    cyc(); settle();
    check("lw_m1_req", mem_req, 1);
    check("lw_m1_read", mem_read, 1);
    check("lw_m1_wr", mem_write, WRITE_IDLE);
    cyc(); settle();
    check("lw_m2_req", mem_req, 1);
    cyc(); settle();
    check("lw_m3_req", mem_req, 1);
    check("lw_m3_fault", fault, 0);
    cyc(); mem_ready = 1'b1; settle();
    check("lw_m4_req", mem_req, 1);
    check("lw_m4_pcw", pc_write, 0);
    cyc(); settle();
    check("lw_w_wbsel", wb_sel, WB_MEM);
    check("lw_w_regw", reg_write, 1);
    check("lw_w_retire", retire, 1);

    // BEQ taken, then not taken.
    cyc();
    set_instr(OPC_BRANCH, 3'b000, F7_BASE);
    branch_taken = 1'b1;
    settle();
    check("lw_instret", instret, 2);
    cyc(); cyc(); settle();
    check("beq_t_pcw", pc_write, 1);
    check("beq_t_pcsrc", pc_src, PC_BRANCH);
    check("beq_t_retire", retire, 1);
    check("beq_t_regw", reg_write, 0);
    check("beq_t_aluop", alu_op, ALU_EQ);
    cyc(); branch_taken = 1'b0; settle();
    check("beq_t_instret", instret, 3);
    check("beq_nt_f_req", mem_req, 1);
    cyc(); cyc(); settle();
    check("beq_nt_pcsrc", pc_src, PC_PLUS4);
    check("beq_nt_pcw", pc_write, 1);
    check("beq_nt_regw", reg_write, 0);

    // JAL and JALR complete in EXEC.
    cyc(); set_instr(OPC_JAL, 3'b000, F7_BASE); settle();
    check("beq_nt_instret", instret, 4);
    cyc(); cyc(); settle();
    check("jal_pcsrc", pc_src, PC_BRANCH);
    check("jal_regw", reg_write, 1);
    check("jal_wbsel", wb_sel, WB_PC4);
    check("jal_retire", retire, 1);
    cyc(); set_instr(OPC_JALR, 3'b000, F7_BASE); settle();
    cyc(); cyc(); settle();
    check("jalr_pcsrc", pc_src, PC_JALR);
    check("jalr_pcw", pc_write, 1);

    // SH with an immediately ready memory: 4 cycles, retires in MEM.
    cyc(); set_instr(OPC_STORE, 3'b001, F7_BASE); settle();
    check("jalr_instret", instret, 6);
    cyc(); cyc(); settle();
    check("sh_e_pcw", pc_write, 0);
    check("sh_e_srcb", alu_src_b, 1);
    cyc(); settle();
    check("sh_m_wr", mem_write, WRITE_HALF);
    check("sh_m_read", mem_read, 0);
    check("sh_m_pcw", pc_write, 1);
    check("sh_m_retire", retire, 1);
    check("sh_m_regw", reg_write, 0);

    // LUI selects a zero A operand.
    cyc(); set_instr(OPC_LUI, 3'b000, F7_BASE); settle();
    check("sh_instret", instret, 7);
    cyc(); cyc(); settle();
    check("lui_e_srca", alu_src_a, SRC_A_ZERO);
    cyc(); settle();
    check("lui_w_srca", alu_src_a, SRC_A_ZERO);
    check("lui_w_wbsel", wb_sel, WB_ALU);

    // SRAI decodes to SRA.
    cyc(); set_instr(OPC_OP_IMM, 3'b101, F7_ALT); settle();
    cyc(); settle();
    check("srai_d_fault", fault, 0);
    cyc(); settle();
    check("srai_e_aluop", alu_op, ALU_SRA);
    check("srai_e_srcb", alu_src_b, 1);
    cyc(); settle();
    check("srai_w_retire", retire, 1);

    // SW interrupted by reset while waiting in MEM.
    cyc(); set_instr(OPC_STORE, 3'b010, F7_BASE); settle();
    check("srai_instret", instret, 9);
    cyc(); cyc(); mem_ready = 1'b0; settle();
    cyc(); settle();
    check("sw_m_wr", mem_write, WRITE_WORD);
    check("sw_m_req", mem_req, 1);
    rst = 1'b1;
    settle();
    check("sw_rst_wr", mem_write, WRITE_IDLE);
    check("sw_rst_req", mem_req, 0);
    check("sw_rst_retire", retire, 0);
    check("sw_rst_instret", instret, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_ready = 1'b1;
    settle();
    check("sw_after_req", mem_req, 1);
    check("sw_after_instret", instret, 0);

    // Illegal LOAD funct3=3 traps from DECODE.
    set_instr(OPC_LOAD, 3'b011, F7_BASE);
    cyc(); settle();
    check("ill_ld_d_fault", fault, 0);
    cyc(); settle();
    check("ill_ld_fault", fault, 1);
    check("ill_ld_cause", fault_cause, CAUSE_ILLEGAL);
    check("ill_ld_req", mem_req, 0);

    // Bus timeout: memory never answers the fetch.
    do_reset();
    set_instr(OPC_OP, 3'b000, F7_BASE);
    mem_ready = 1'b0;
    settle();
    check("to_rst_fault", fault, 0);
    check("to_rst_cause", fault_cause, CAUSE_NONE);
    check("to_w1_req", mem_req, 1);
    cyc(); cyc(); cyc(); settle();
    check("to_w4_req", mem_req, 1);
    check("to_w4_fault", fault, 0);
    cyc(); settle();
    check("to_fault", fault, 1);
    check("to_cause", fault_cause, CAUSE_BUS);
    check("to_req_drop", mem_req, 0);
    check("to_read_drop", mem_read, 0);
    mem_ready = 1'b1;
    cyc(); cyc(); settle();
    check("to_hold_fault", fault, 1);
    check("to_hold_irw", ir_write, 0);
    check("to_hold_pcw", pc_write, 0);
    check("to_hold_req", mem_req, 0);

    // funct7=0000001: illegal without the M extension, MDU operation with it.
    do_reset();
    set_instr(OPC_OP, 3'b100, F7_MULDIV);
    settle();
    check("mdu_f_m_instret", m_instret, 0);
    cyc(); cyc(); settle();
    check("mdu_e_start", m_mdu_start, 1);
    check("mdu_e_op", m_mdu_op, 3'b100);
    check("nom_e_start", mdu_start, 0);
    cyc(); settle();
    check("nom_fault", fault, 1);
    check("nom_cause", fault_cause, CAUSE_ILLEGAL);
    check("mdu_w1_start", m_mdu_start, 0);
    check("mdu_w1_fault", m_fault, 0);
    cyc(); cyc(); cyc(); settle();
    check("mdu_w4_regw", m_reg_write, 0);
    cyc(); mdu_done = 1'b1; settle();
    check("mdu_w5_retire", m_retire, 0);
    cyc(); mdu_done = 1'b0; settle();
    check("mdu_wb_wbsel", m_wb_sel, WB_MDU);
    check("mdu_wb_regw", m_reg_write, 1);
    check("mdu_wb_retire", m_retire, 1);
    cyc(); settle();
    check("mdu_instret", m_instret, 1);
    check("mdu_next_req", m_mem_req, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
